// File: rtl/btn_debounce.sv
// Multi-button debouncer with edge pulses and hold-to-repeat.
// Each button gets its own lane, and lanes share nothing but the clock and reset.
module btn_debounce_lane #(
    parameter int DB_CYCLES  = 250000,
    parameter int RPT_DELAY  = 12500000,
    parameter int RPT_PERIOD = 2500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic btn,        // raw pin, already polarity-normalized
    output logic held,
    output logic press,
    output logic release_p,
    output logic rpt
);
    localparam int DBW  = $clog2(DB_CYCLES + 1);
    localparam int RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [RW-1:0]  RLD_DELAY = RW'(RPT_DELAY - 1);
    localparam logic [RW-1:0]  RLD_PER   = RW'(RPT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic [1:0]     sync;
    logic [DBW-1:0] cnt;
    logic [RW-1:0]  rcnt;
    state_t         state;
    logic           qual, go_press, go_rel;

    // qual marks the edge on which the debounced level flips
    always_comb begin
        qual     = (sync[1] != held) && (cnt == DB_LAST);
        go_press = qual && !held;
        go_rel   = qual && held;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync      <= '0;
            cnt       <= '0;
            held      <= 1'b0;
            press     <= 1'b0;
            release_p <= 1'b0;
            rpt       <= 1'b0;
            rcnt      <= '0;
            state     <= IDLE;
        end else begin
            sync      <= {sync[0], btn};
            press     <= go_press;
            release_p <= go_rel;
            rpt       <= 1'b0;

            if (sync[1] == held)
                cnt <= '0;
            else if (qual) begin
                cnt  <= '0;
                held <= ~held;
            end else
                cnt <= cnt + 1'b1;

            // The press edge loads the counter so the first repeat lands RPT_DELAY after o_press
            case (state)
                IDLE: begin
                    if (go_press) begin
                        state <= DELAY;
                        rcnt  <= RLD_DELAY;
                    end
                end
                DELAY, REPEAT: begin
                    if (go_rel) begin
                        state <= IDLE;
                        rcnt  <= '0;
                    end else if (rcnt == '0) begin
                        rpt   <= 1'b1;
                        rcnt  <= RLD_PER;
                        state <= REPEAT;
                    end else
                        rcnt <= rcnt - 1'b1;
                end
                default: begin
                    state <= IDLE;
                    rcnt  <= '0;
                end
            endcase
        end
    end
endmodule

module btn_debounce #(
    parameter int NBTN       = 7,
    parameter int DB_CYCLES  = 250000,
    parameter int RPT_DELAY  = 12500000,
    parameter int RPT_PERIOD = 2500000,
    parameter logic [NBTN-1:0] ACTIVE_LOW = NBTN'(7'b0000001)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NBTN-1:0] i_btn,
    output logic [NBTN-1:0] o_held,
    output logic [NBTN-1:0] o_press,
    output logic [NBTN-1:0] o_release,
    output logic [NBTN-1:0] o_repeat
);
    logic [NBTN-1:0] norm;

    assign norm = i_btn ^ ACTIVE_LOW;

    for (genvar l = 0; l < NBTN; l++) begin : g_lane
        btn_debounce_lane #(
            .DB_CYCLES (DB_CYCLES),
            .RPT_DELAY (RPT_DELAY),
            .RPT_PERIOD(RPT_PERIOD)
        ) u_lane (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .btn      (norm[l]),
            .held     (o_held[l]),
            .press    (o_press[l]),
            .release_p(o_release[l]),
            .rpt      (o_repeat[l])
        );
    end
endmodule
